// File: rtl/operand_fetch_pkg.sv
// Shared constants for the operand fetch slice.
//   XLEN     operand/data width
//   NREG     number of architectural registers (x0 reads as zero)
//   REG_AW   register index width
//   REG_ZERO index of the hardwired zero register
package operand_fetch_pkg;

    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;

    localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/operand_fetch_reg_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when an
// instruction that writes that register is issued, cleared on writeback or
// when the issuing instruction is flushed before execute.
// Ports:
//   clock, reset          rising-edge clock, async active-high reset
//   set_en, set_idx       mark a register as having a write in flight
//   clr_wb_en, clr_wb_idx writeback clear
//   clr_fl_en, clr_fl_idx flush clear (discarded instruction's destination)
//   chk_rs1/rs2/rd        indices to look up
//   pend_rs1/rs2/rd       pending state of the looked-up registers
module operand_fetch_reg_scoreboard
    import operand_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              set_en,
    input  logic [REG_AW-1:0] set_idx,
    input  logic              clr_wb_en,
    input  logic [REG_AW-1:0] clr_wb_idx,
    input  logic              clr_fl_en,
    input  logic [REG_AW-1:0] clr_fl_idx,
    input  logic [REG_AW-1:0] chk_rs1,
    input  logic [REG_AW-1:0] chk_rs2,
    input  logic [REG_AW-1:0] chk_rd,
    output logic              pend_rs1,
    output logic              pend_rs2,
    output logic              pend_rd
);

    logic [NREG-1:0] pending;
    logic [NREG-1:0] pending_next;

    // Clears are applied before the set so that a register being issued in
    // the same cycle its older write retires stays pending for the new one.
    // x0 is forced clear so it can never cause a stall.
    always_comb begin
        pending_next = pending;
        if (clr_wb_en) begin
            pending_next[clr_wb_idx] = 1'b0;
        end
        if (clr_fl_en) begin
            pending_next[clr_fl_idx] = 1'b0;
        end
        if (set_en) begin
            pending_next[set_idx] = 1'b1;
        end
        pending_next[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            pending <= pending_next;
        end
    end

    assign pend_rs1 = pending[chk_rs1];
    assign pend_rs2 = pending[chk_rs2];
    assign pend_rd  = pending[chk_rd];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch: drives the register bank read selects from the decoded
// instruction, forwards same-cycle writeback data, stalls on RAW/WAW hazards
// and hands registered operands to execute over a valid/ready handshake.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   flush                        discard the instruction held for execute
//   dec_valid/dec_ready          decode handshake
//   dec_rs1/rs2/rd/rd_we         decoded instruction fields
//   rf_select_a/b, rf_data_a/b   register bank read ports (combinational)
//   wb_valid/wb_rd/wb_data       writeback strobe shared with the bank
//   ex_valid/ex_ready            execute handshake
//   ex_op_a/op_b/rd/rd_we        registered operands and destination
module operand_fetch
    import operand_fetch_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              dec_valid,
    output logic              dec_ready,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    input  logic [REG_AW-1:0] dec_rd,
    input  logic              dec_rd_we,
    output logic [REG_AW-1:0] rf_select_a,
    output logic [REG_AW-1:0] rf_select_b,
    input  logic [XLEN-1:0]   rf_data_a,
    input  logic [XLEN-1:0]   rf_data_b,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [XLEN-1:0]   ex_op_a,
    output logic [XLEN-1:0]   ex_op_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rd_we
);

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            pend_rs1;
    logic            pend_rs2;
    logic            pend_rd;
    logic            fwd_rs1;
    logic            fwd_rs2;
    logic            fwd_rd;
    logic            stall;
    logic            transfer;
    logic            flush_clear;

    assign rf_select_a = dec_rs1;
    assign rf_select_b = dec_rs2;

    assign fwd_rs1 = wb_valid && (wb_rd == dec_rs1);
    assign fwd_rs2 = wb_valid && (wb_rd == dec_rs2);
    assign fwd_rd  = wb_valid && (wb_rd == dec_rd);

    // The bank only commits the writeback at the clock edge, so a register
    // being written this cycle must be taken from wb_data, not the bank.
    always_comb begin
        op_a = rf_data_a;
        op_b = rf_data_b;
        if (dec_rs1 == REG_ZERO) begin
            op_a = '0;
        end else if (fwd_rs1) begin
            op_a = wb_data;
        end
        if (dec_rs2 == REG_ZERO) begin
            op_b = '0;
        end else if (fwd_rs2) begin
            op_b = wb_data;
        end
    end

    // A pending register retiring this very cycle is not a hazard: its value
    // is forwarded and its pending bit is being cleared. The rd check keeps
    // at most one outstanding write per register.
    assign stall = (pend_rs1 && !fwd_rs1) ||
                   (pend_rs2 && !fwd_rs2) ||
                   (dec_rd_we && pend_rd && !fwd_rd);

    assign dec_ready   = (!ex_valid || ex_ready) && !stall && !flush;
    assign transfer    = dec_valid && dec_ready;
    assign flush_clear = flush && ex_valid && ex_rd_we;

    operand_fetch_reg_scoreboard u_scoreboard (
        .clock      (clock),
        .reset      (reset),
        .set_en     (transfer && dec_rd_we),
        .set_idx    (dec_rd),
        .clr_wb_en  (wb_valid),
        .clr_wb_idx (wb_rd),
        .clr_fl_en  (flush_clear),
        .clr_fl_idx (ex_rd),
        .chk_rs1    (dec_rs1),
        .chk_rs2    (dec_rs2),
        .chk_rd     (dec_rd),
        .pend_rs1   (pend_rs1),
        .pend_rs2   (pend_rs2),
        .pend_rd    (pend_rd)
    );

    // Output register: loads on transfer, otherwise holds its fields and only
    // drops valid when execute consumes the entry or it is flushed.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid <= 1'b0;
            ex_op_a  <= '0;
            ex_op_b  <= '0;
            ex_rd    <= '0;
            ex_rd_we <= 1'b0;
        end else if (transfer) begin
            ex_valid <= 1'b1;
            ex_op_a  <= op_a;
            ex_op_b  <= op_b;
            ex_rd    <= dec_rd;
            ex_rd_we <= dec_rd_we;
        end else if (flush || ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        dec_valid = 1'b0;
    logic        dec_ready;
    logic [4:0]  dec_rs1 = '0;
    logic [4:0]  dec_rs2 = '0;
    logic [4:0]  dec_rd = '0;
    logic        dec_rd_we = 1'b0;
    logic [4:0]  rf_select_a;
    logic [4:0]  rf_select_b;
    logic [31:0] rf_data_a;
    logic [31:0] rf_data_b;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic        ex_valid;
    logic        ex_ready = 1'b0;
    logic [31:0] ex_op_a;
    logic [31:0] ex_op_b;
    logic [4:0]  ex_rd;
    logic        ex_rd_we;

    typedef struct {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [4:0]  rd;
        logic        rd_we;
    } exp_t;

    // Bench-owned register bank and reference state.
    logic [31:0] bank [32];
    bit          m_pend [32];
    bit          m_valid;
    logic [4:0]  m_rd;
    bit          m_we;
    exp_t        exp_q [$];
    logic [4:0]  wbq [$];
    bit          last_xfer;

    int n_tests = 0;
    int n_fail = 0;

    assign rf_data_a = bank[rf_select_a];
    assign rf_data_b = bank[rf_select_b];

    always #5 clock = ~clock;

    operand_fetch dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .dec_valid   (dec_valid),
        .dec_ready   (dec_ready),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .dec_rd_we   (dec_rd_we),
        .rf_select_a (rf_select_a),
        .rf_select_b (rf_select_b),
        .rf_data_a   (rf_data_a),
        .rf_data_b   (rf_data_b),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_op_a     (ex_op_a),
        .ex_op_b     (ex_op_b),
        .ex_rd       (ex_rd),
        .ex_rd_we    (ex_rd_we)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // A register is a hazard if a write to it is still outstanding and that
    // write is not retiring in the current cycle.
    function automatic bit model_hz(input logic [4:0] r, input bit wbv, input logic [4:0] wrd);
        return (r != 0) && m_pend[r] && !(wbv && wrd == r);
    endfunction

    function automatic logic [31:0] model_src(input logic [4:0] r, input bit wbv,
                                              input logic [4:0] wrd, input logic [31:0] wdat);
        if (r == 0) return 32'h0;
        if (wbv && wrd == r) return wdat;
        return bank[r];
    endfunction

    // One clock cycle: drive, predict and check the handshake, push the
    // expected execute entry, then advance the reference state after the edge.
    task automatic applyStimulus(input bit dv, input logic [4:0] r1, input logic [4:0] r2,
                                 input logic [4:0] rd, input bit we, input bit exr,
                                 input bit fl, input bit wbv, input logic [4:0] wrd,
                                 input logic [31:0] wdat);
        bit   stall;
        bit   exp_ready;
        bit   xfer;
        bit   leaving;
        exp_t e;
        @(negedge clock);
        dec_valid = dv;
        dec_rs1   = r1;
        dec_rs2   = r2;
        dec_rd    = rd;
        dec_rd_we = we;
        ex_ready  = exr;
        flush     = fl;
        wb_valid  = wbv;
        wb_rd     = wrd;
        wb_data   = wdat;
        #1;
        stall     = model_hz(r1, wbv, wrd) || model_hz(r2, wbv, wrd) || (we && model_hz(rd, wbv, wrd));
        exp_ready = (!m_valid || exr) && !stall && !fl;
        checkOutput("dec_ready", {31'b0, dec_ready}, {31'b0, exp_ready});
        checkOutput("ex_valid", {31'b0, ex_valid}, {31'b0, m_valid});
        checkOutput("rf_select_a", {27'b0, rf_select_a}, {27'b0, r1});
        checkOutput("rf_select_b", {27'b0, rf_select_b}, {27'b0, r2});
        xfer = dv && exp_ready;
        if (fl && m_valid && exp_q.size() > 0) void'(exp_q.pop_front());
        if (xfer) begin
            e.op_a  = model_src(r1, wbv, wrd, wdat);
            e.op_b  = model_src(r2, wbv, wrd, wdat);
            e.rd    = rd;
            e.rd_we = we;
            exp_q.push_back(e);
        end
        last_xfer = xfer;
        @(posedge clock);
        #1;
        leaving = m_valid && exr && !fl;
        if (leaving && m_we) wbq.push_back(m_rd);
        if (wbv) begin
            m_pend[wrd] = 0;
            bank[wrd]   = wdat;
            for (int i = 0; i < wbq.size(); i++) begin
                if (wbq[i] == wrd) begin
                    wbq.delete(i);
                    break;
                end
            end
        end
        if (fl && m_valid && m_we) m_pend[m_rd] = 0;
        if (xfer && we && rd != 0) m_pend[rd] = 1;
        if (xfer) begin
            m_valid = 1;
            m_rd    = rd;
            m_we    = we;
        end else if (fl || exr) begin
            m_valid = 0;
        end
    endtask

    task automatic idle(input bit exr);
        applyStimulus(0, 0, 0, 0, 0, exr, 0, 0, 0, 0);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset     = 1'b1;
        dec_valid = 1'b0;
        flush     = 1'b0;
        wb_valid  = 1'b0;
        ex_ready  = 1'b0;
        #1;
        checkOutput("reset ex_valid", {31'b0, ex_valid}, 32'h0);
        checkOutput("reset ex_op_a", ex_op_a, 32'h0);
        checkOutput("reset ex_op_b", ex_op_b, 32'h0);
        checkOutput("reset ex_rd", {27'b0, ex_rd}, 32'h0);
        checkOutput("reset ex_rd_we", {31'b0, ex_rd_we}, 32'h0);
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_valid = 0;
        m_rd    = 0;
        m_we    = 0;
        exp_q.delete();
        wbq.delete();
        @(posedge clock);
        #2;
        reset = 1'b0;
    endtask

    // Monitor: whenever execute sees a valid entry, compare it with the oldest
    // expected entry; retire that entry when execute accepts it.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            #3;
            if (!reset && ex_valid && !flush) begin
                if (exp_q.size() == 0) begin
                    checkOutput("ex_unexpected", {31'b0, ex_valid}, 32'h0);
                end else begin
                    e = exp_q[0];
                    checkOutput("ex_op_a", ex_op_a, e.op_a);
                    checkOutput("ex_op_b", ex_op_b, e.op_b);
                    checkOutput("ex_rd", {27'b0, ex_rd}, {27'b0, e.rd});
                    checkOutput("ex_rd_we", {31'b0, ex_rd_we}, {31'b0, e.rd_we});
                    if (ex_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit          dv;
        bit          we;
        bit          exr;
        bit          fl;
        bit          wbv;
        bit          hold;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic [4:0]  rd;
        logic [4:0]  wrd;
        logic [4:0]  cand;
        logic [31:0] wdat;

        for (int i = 0; i < 32; i++) bank[i] = $urandom;
        doReset();

        // Back-to-back independent instructions.
        bank[1] = 32'h11;
        bank[2] = 32'h22;
        applyStimulus(1, 1, 2, 10, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 2, 1, 11, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 1, 1, 12, 0, 1, 0, 0, 0, 0);
        idle(1);

        // RAW stall resolved by a forwarded writeback.
        bank[5] = 32'h55;
        applyStimulus(1, 1, 2, 5, 1, 1, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 9, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 9, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 5, 0, 9, 0, 1, 0, 1, 5, 32'hCAFE);
        idle(1);

        // x0 reads as zero even with bank and writeback driving other values.
        bank[0] = 32'hDEAD;
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 1, 0, 32'hBEEF);
        applyStimulus(1, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        idle(1);

        // Backpressure: three cycles of ex_ready low, then drain.
        applyStimulus(1, 1, 2, 13, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 2, 2, 14, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 2, 14, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 2, 14, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 2, 2, 14, 0, 1, 0, 0, 0, 0);
        idle(1);
        idle(1);

        // Flush of a held writer releases its reader.
        applyStimulus(1, 0, 0, 7, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 7, 0, 15, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 7, 0, 15, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Writeback to x3 in the same cycle a new write to x3 issues.
        applyStimulus(1, 0, 0, 3, 1, 1, 0, 1, 3, 32'h33);
        applyStimulus(1, 3, 0, 16, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 3, 0, 16, 0, 1, 0, 1, 3, 32'h333);
        idle(1);

        // Reset while an entry is held for execute.
        applyStimulus(1, 1, 2, 6, 1, 1, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        doReset();
        applyStimulus(1, 6, 0, 17, 0, 1, 0, 0, 0, 0);
        idle(1);

        // Randomized traffic on a small register window to force hazards.
        hold = 0;
        dv = 0; r1 = 0; r2 = 0; rd = 0; we = 0;
        for (int c = 0; c < 1500; c++) begin
            if (!hold) begin
                dv = ($urandom % 4) != 0;
                r1 = 5'($urandom % 8);
                r2 = 5'($urandom % 8);
                rd = 5'($urandom % 8);
                we = ($urandom % 2) != 0;
            end
            exr  = ($urandom % 4) != 0;
            fl   = !exr && (($urandom % 6) == 0);
            wbv  = 0;
            wrd  = 0;
            wdat = $urandom;
            if (wbq.size() > 0 && ($urandom % 2) == 0) begin
                wbv = 1;
                wrd = wbq[0];
            end else if (($urandom % 8) == 0) begin
                cand = 5'($urandom % 8);
                if (!m_pend[cand]) begin
                    wbv = 1;
                    wrd = cand;
                end
            end
            applyStimulus(dv, r1, r2, rd, we, exr, fl, wbv, wrd, wdat);
            hold = dv && !last_xfer;
        end

        // Drain everything still in flight.
        for (int c = 0; c < 40; c++) begin
            if (wbq.size() > 0) applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, wbq[0], $urandom);
            else idle(1);
        end
        checkOutput("drain exp_q", exp_q.size(), 32'h0);
        checkOutput("drain wbq", wbq.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
